// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache set controller and its victim selector.
// Holds the controller state enum and the width and ceiling of the per-way
// age field used for oldest-way replacement.
package cache_pkg;

    // Age is a small saturating counter per way. AGE_MAX marks the oldest line
    // and is also the age an empty way is treated as having.
    localparam int              AGE_W   = 2;
    localparam logic [AGE_W-1:0] AGE_MAX = 2'd3;

    // Controller sequence for a single CPU byte access.
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WRITEBACK,
        FILL,
        ACCESS,
        RESP
    } ctrlState_e;

endpackage

// File: rtl/cache_victim_select.sv
// cache_victim_select
// Purely combinational replacement choice for one set.
// Picks the lowest-index empty way if one exists. Otherwise it picks the way
// with the highest age, and on an age tie the lowest index wins.
// Ports:
//   line_empty_i     per-way empty flag
//   line_age_i       per-way age, way i at [AGE_W*i +: AGE_W]
//   victim_onehot_o  chosen way as a one-hot vector
//   victim_idx_o     chosen way as a binary index
module cache_victim_select
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int IDX_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]       line_empty_i,
    input  logic [AGE_W*NUM_WAYS-1:0] line_age_i,
    output logic [NUM_WAYS-1:0]       victim_onehot_o,
    output logic [IDX_W-1:0]          victim_idx_o
);

    logic             foundEmpty;
    logic [IDX_W-1:0] emptyIdx;
    logic [IDX_W-1:0] oldestIdx;
    logic [AGE_W-1:0] oldestAge;

    // Two independent scans feed the final choice.
    // The first scan finds the first empty way. The second finds the oldest
    // way. The oldest scan uses a strict greater-than, so on a tie the
    // earliest (lowest-index) way is kept.
    always_comb begin
        foundEmpty = 1'b0;
        emptyIdx   = '0;
        oldestIdx  = '0;
        oldestAge  = line_age_i[AGE_W-1:0];
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!foundEmpty && line_empty_i[i]) begin
                foundEmpty = 1'b1;
                emptyIdx   = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_WAYS; i++) begin
            if (line_age_i[AGE_W*i +: AGE_W] > oldestAge) begin
                oldestAge = line_age_i[AGE_W*i +: AGE_W];
                oldestIdx = IDX_W'(i);
            end
        end
        victim_idx_o                  = foundEmpty ? emptyIdx : oldestIdx;
        victim_onehot_o               = '0;
        victim_onehot_o[victim_idx_o] = 1'b1;
    end

endmodule

// File: rtl/cache_set_controller.sv
// cache_set_controller
// Sequences one N-way set of cache lines for byte reads and writes from the CPU.
// For each request it performs a lookup and a tag compare. On a miss it picks
// a victim, writes the victim back if it is dirty, and refills the line. It
// then issues the access to the target way, updates the LRU ages, and returns
// one byte to the CPU.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i  CPU request, accepted when cpu_ready_o is high
//   cpu_ready_o, cpu_done_o        accept strobe (IDLE only), 1-cycle completion pulse
//   cpu_rdata_o                    returned byte (a write echoes the written byte)
//   multi_hit_o                    pulse when more than one way hit
//   line_hit/empty/dirty/age/tag/rdata_i  per-way status from the line array
//   line_ready_o, line_addr_o, line_wdata_o, line_sel_o  line array request bus
//   line_try_read_o/try_write_o    access strobes, qualified by line_sel_o
//   line_reset_age_o/incr_age_o    per-way LRU update
//   mem_rd_req_o/mem_wr_req_o/mem_addr_o/mem_ack_i  refill and write-back handshake
module cache_set_controller
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 32,
    parameter int TAG_SIZE = 19,
    parameter int OFFSET_W = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cpu_req_i,
    input  logic                         cpu_we_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [7:0]                   cpu_wdata_i,
    output logic                         cpu_ready_o,
    output logic                         cpu_done_o,
    output logic [7:0]                   cpu_rdata_o,
    output logic                         multi_hit_o,
    input  logic [NUM_WAYS-1:0]          line_hit_i,
    input  logic [NUM_WAYS-1:0]          line_empty_i,
    input  logic [NUM_WAYS-1:0]          line_dirty_i,
    input  logic [AGE_W*NUM_WAYS-1:0]    line_age_i,
    input  logic [TAG_SIZE*NUM_WAYS-1:0] line_tag_i,
    input  logic [8*NUM_WAYS-1:0]        line_rdata_i,
    output logic                         line_ready_o,
    output logic [ADDR_W-1:0]            line_addr_o,
    output logic [7:0]                   line_wdata_o,
    output logic [NUM_WAYS-1:0]          line_sel_o,
    output logic                         line_try_read_o,
    output logic                         line_try_write_o,
    output logic [NUM_WAYS-1:0]          line_reset_age_o,
    output logic [NUM_WAYS-1:0]          line_incr_age_o,
    output logic                         mem_rd_req_o,
    output logic                         mem_wr_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic                         mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_WAYS);

    ctrlState_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [IDX_W-1:0]  target_q, target_d;

    logic                anyHit;
    logic                multiHit;
    logic [IDX_W-1:0]    hitIdx;
    logic [NUM_WAYS-1:0] victimOnehot;
    logic [IDX_W-1:0]    victimIdx;
    logic                victimDirty;
    logic [NUM_WAYS-1:0] targetOnehot;
    logic [AGE_W-1:0]    targetAge;

    cache_victim_select #(
        .NUM_WAYS (NUM_WAYS),
        .IDX_W    (IDX_W)
    ) u_victim (
        .line_empty_i    (line_empty_i),
        .line_age_i      (line_age_i),
        .victim_onehot_o (victimOnehot),
        .victim_idx_o    (victimIdx)
    );

    // Hit priority encoder.
    // The downward scan leaves the lowest hitting way in hitIdx.
    // Clearing the lowest set bit (x & (x-1)) leaves a nonzero value exactly
    // when two or more ways report a hit.
    // A write-back is needed only if the chosen victim is both dirty and
    // holds a valid line.
    always_comb begin
        anyHit   = |line_hit_i;
        multiHit = (line_hit_i & (line_hit_i - NUM_WAYS'(1))) != '0;
        hitIdx   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (line_hit_i[i]) begin
                hitIdx = IDX_W'(i);
            end
        end
        victimDirty = |(victimOnehot & line_dirty_i & ~line_empty_i);
    end

    // State register plus the latched request and target way.
    // Reset returns the controller to IDLE and clears the latched request,
    // which drops any outstanding memory request and any access strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            target_q <= target_d;
        end
    end

    // Next-state logic.
    // The request is latched only in IDLE, so the CPU side is ignored for the
    // rest of the sequence. The target way is fixed in COMPARE: the lowest
    // hitting way on a hit, otherwise the victim. mem_ack_i only moves the
    // FSM forward while a memory request is actually outstanding.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    we_d    = cpu_we_i;
                    wdata_d = cpu_wdata_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP:  state_d = COMPARE;
            COMPARE: begin
                if (anyHit) begin
                    target_d = hitIdx;
                    state_d  = ACCESS;
                end else begin
                    target_d = victimIdx;
                    state_d  = victimDirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: if (mem_ack_i) state_d = FILL;
            FILL:      if (mem_ack_i) state_d = ACCESS;
            ACCESS:    state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode, driven purely from the current state and the latched request.
    // LRU update in ACCESS: the target's age is cleared. Every other valid way
    // that was no older than the target ages by one, saturating at AGE_MAX.
    // An empty target counts as AGE_MAX, so a fresh fill ages every valid way.
    always_comb begin
        cpu_ready_o      = 1'b0;
        cpu_done_o       = 1'b0;
        cpu_rdata_o      = '0;
        multi_hit_o      = 1'b0;
        line_ready_o     = 1'b0;
        line_addr_o      = addr_q;
        line_wdata_o     = wdata_q;
        line_sel_o       = '0;
        line_try_read_o  = 1'b0;
        line_try_write_o = 1'b0;
        line_reset_age_o = '0;
        line_incr_age_o  = '0;
        mem_rd_req_o     = 1'b0;
        mem_wr_req_o     = 1'b0;
        mem_addr_o       = '0;
        targetOnehot     = '0;
        targetOnehot[target_q] = 1'b1;
        targetAge = line_empty_i[target_q] ? AGE_MAX
                                           : line_age_i[int'(target_q)*AGE_W +: AGE_W];
        unique case (state_q)
            IDLE:    cpu_ready_o  = 1'b1;
            LOOKUP:  line_ready_o = 1'b1;
            COMPARE: multi_hit_o  = multiHit;
            WRITEBACK: begin
                mem_wr_req_o = 1'b1;
                mem_addr_o   = {line_tag_i[int'(target_q)*TAG_SIZE +: TAG_SIZE],
                                addr_q[ADDR_W-TAG_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            FILL: begin
                mem_rd_req_o = 1'b1;
                mem_addr_o   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            ACCESS: begin
                line_ready_o     = 1'b1;
                line_sel_o       = targetOnehot;
                line_try_read_o  = ~we_q;
                line_try_write_o = we_q;
                line_reset_age_o = targetOnehot;
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (i != int'(target_q) && !line_empty_i[i] &&
                        line_age_i[i*AGE_W +: AGE_W] <= targetAge &&
                        line_age_i[i*AGE_W +: AGE_W] < AGE_MAX) begin
                        line_incr_age_o[i] = 1'b1;
                    end
                end
            end
            RESP: begin
                cpu_done_o  = 1'b1;
                cpu_rdata_o = we_q ? wdata_q : line_rdata_i[int'(target_q)*8 +: 8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_set_controller.sv
// tb_cache_set_controller
// Drives the set controller against a behavioural line-array model held in
// the bench. For every request, the bench works out the target way, the
// write-back and refill addresses, the LRU vectors, and the returned byte
// directly from the replacement rules. It then walks the transaction cycle by
// cycle and compares the DUT outputs against those predictions.
module tb_cache_set_controller;

    localparam int NUM_WAYS = 4;
    localparam int ADDR_W   = 32;
    localparam int TAG_SIZE = 19;
    localparam int OFFSET_W = 6;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         cpu_req, cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [7:0]                   cpu_wdata;
    logic                         cpu_ready, cpu_done, multi_hit;
    logic [7:0]                   cpu_rdata;
    logic [NUM_WAYS-1:0]          line_hit, line_empty, line_dirty;
    logic [2*NUM_WAYS-1:0]        line_age;
    logic [TAG_SIZE*NUM_WAYS-1:0] line_tag;
    logic [8*NUM_WAYS-1:0]        line_rdata;
    logic                         line_ready, line_try_read, line_try_write;
    logic [ADDR_W-1:0]            line_addr, mem_addr;
    logic [7:0]                   line_wdata;
    logic [NUM_WAYS-1:0]          line_sel, line_reset_age, line_incr_age;
    logic                         mem_rd_req, mem_wr_req, mem_ack;

    // Behavioural line-array state, packed onto the DUT's per-way buses below.
    logic [NUM_WAYS-1:0] lineHit, lineEmpty, lineDirty;
    logic [1:0]          lineAge  [NUM_WAYS];
    logic [TAG_SIZE-1:0] lineTag  [NUM_WAYS];
    logic [7:0]          lineData [NUM_WAYS];

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    assign line_hit   = lineHit;
    assign line_empty = lineEmpty;
    assign line_dirty = lineDirty;
    for (genvar g = 0; g < NUM_WAYS; g++) begin : gPack
        assign line_age[2*g +: 2]               = lineAge[g];
        assign line_tag[TAG_SIZE*g +: TAG_SIZE] = lineTag[g];
        assign line_rdata[8*g +: 8]             = lineData[g];
    end

    cache_set_controller #(
        .NUM_WAYS (NUM_WAYS),
        .ADDR_W   (ADDR_W),
        .TAG_SIZE (TAG_SIZE),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cpu_req_i        (cpu_req),
        .cpu_we_i         (cpu_we),
        .cpu_addr_i       (cpu_addr),
        .cpu_wdata_i      (cpu_wdata),
        .cpu_ready_o      (cpu_ready),
        .cpu_done_o       (cpu_done),
        .cpu_rdata_o      (cpu_rdata),
        .multi_hit_o      (multi_hit),
        .line_hit_i       (line_hit),
        .line_empty_i     (line_empty),
        .line_dirty_i     (line_dirty),
        .line_age_i       (line_age),
        .line_tag_i       (line_tag),
        .line_rdata_i     (line_rdata),
        .line_ready_o     (line_ready),
        .line_addr_o      (line_addr),
        .line_wdata_o     (line_wdata),
        .line_sel_o       (line_sel),
        .line_try_read_o  (line_try_read),
        .line_try_write_o (line_try_write),
        .line_reset_age_o (line_reset_age),
        .line_incr_age_o  (line_incr_age),
        .mem_rd_req_o     (mem_rd_req),
        .mem_wr_req_o     (mem_wr_req),
        .mem_addr_o       (mem_addr),
        .mem_ack_i        (mem_ack)
    );

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Fill the set with random contents: a mix of empty, dirty and hit ways and arbitrary ages.
    task automatic randomizeSet();
        lineEmpty = NUM_WAYS'($urandom & $urandom);
        lineDirty = NUM_WAYS'($urandom);
        lineHit   = ($urandom_range(0, 2) == 0) ? NUM_WAYS'($urandom) : '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            lineAge[i]  = 2'($urandom);
            lineTag[i]  = TAG_SIZE'($urandom);
            lineData[i] = 8'($urandom);
        end
    endtask

    // Issue one request and follow it through to completion.
    // Every observable output is checked at each step against values
    // predicted from the replacement and LRU rules. Afterwards the
    // line-array model is updated the way real lines would be.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [7:0] wdata, input int ackDelay);
        int                  t;
        int                  hits;
        int                  maxAge;
        int                  tAge;
        int                  guard;
        int                  emptyWays[$];
        bit                  needWb, needFill;
        logic [NUM_WAYS-1:0] expSel, expIncr;
        logic [ADDR_W-1:0]   expWbAddr, expFillAddr;
        logic [7:0]          expRdata;

        hits = $countones(lineHit);
        t    = -1;
        if (hits > 0) begin
            for (int i = 0; i < NUM_WAYS; i++) if (lineHit[i] && t < 0) t = i;
        end else begin
            for (int i = 0; i < NUM_WAYS; i++) if (lineEmpty[i]) emptyWays.push_back(i);
            if (emptyWays.size() > 0) begin
                t = emptyWays[0];
            end else begin
                maxAge = 0;
                for (int i = 0; i < NUM_WAYS; i++) if (int'(lineAge[i]) > maxAge) maxAge = lineAge[i];
                for (int i = 0; i < NUM_WAYS; i++) if (int'(lineAge[i]) == maxAge && t < 0) t = i;
            end
        end
        needFill    = (hits == 0);
        needWb      = needFill && lineDirty[t] && !lineEmpty[t];
        expSel      = '0;
        expSel[t]   = 1'b1;
        tAge        = lineEmpty[t] ? 3 : int'(lineAge[t]);
        expIncr     = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (i != t && !lineEmpty[i] && int'(lineAge[i]) <= tAge && lineAge[i] < 2'd3)
                expIncr[i] = 1'b1;
        expWbAddr   = {lineTag[t], addr[ADDR_W-TAG_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
        expFillAddr = {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

        guard = 0;
        while (cpu_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_ready", cpu_ready, 1'b1);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;

        // LOOKUP: the request is held with scrambled data and a stray ack, and both must be ignored.
        @(negedge clk);
        checkOutput("lookup_ready", {cpu_ready, line_ready}, 2'b01);
        checkOutput("lookup_strobes", {line_try_read, line_try_write, mem_rd_req, mem_wr_req}, 4'b0);
        checkOutput("lookup_addr", line_addr, addr);
        cpu_addr  = $urandom;
        cpu_wdata = 8'($urandom);
        mem_ack   = 1'($urandom_range(0, 1));

        // COMPARE
        @(negedge clk);
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        checkOutput("compare_multi_hit", multi_hit, (hits > 1));
        checkOutput("compare_mem_idle", {mem_wr_req, mem_rd_req}, 2'b00);
        @(negedge clk);

        if (needWb) begin
            for (int d = 0; d <= ackDelay; d++) begin
                checkOutput("wb_req", {mem_wr_req, mem_rd_req}, 2'b10);
                checkOutput("wb_addr", mem_addr, expWbAddr);
                if (d == ackDelay) mem_ack = 1'b1;
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end
        if (needFill) begin
            for (int d = 0; d <= ackDelay; d++) begin
                checkOutput("fill_req", {mem_wr_req, mem_rd_req}, 2'b01);
                checkOutput("fill_addr", mem_addr, expFillAddr);
                if (d == ackDelay) mem_ack = 1'b1;
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end

        // ACCESS
        checkOutput("access_ready_done", {line_ready, cpu_done}, 2'b10);
        checkOutput("access_sel", line_sel, expSel);
        checkOutput("access_rw", {line_try_read, line_try_write}, {~we, we});
        checkOutput("access_reset_age", line_reset_age, expSel);
        checkOutput("access_incr_age", line_incr_age, expIncr);
        checkOutput("access_mem_idle", {mem_wr_req, mem_rd_req}, 2'b00);
        checkOutput("access_wdata", line_wdata, wdata);
        checkOutput("access_addr", line_addr, addr);
        lineData[t] = 8'($urandom);
        expRdata    = we ? wdata : lineData[t];

        // RESP
        @(negedge clk);
        checkOutput("resp_done", {cpu_done, cpu_ready}, 2'b10);
        checkOutput("resp_rdata", cpu_rdata, expRdata);
        checkOutput("resp_addr", line_addr, addr);

        @(negedge clk);
        checkOutput("back_to_idle", {cpu_ready, cpu_done}, 2'b10);

        for (int i = 0; i < NUM_WAYS; i++) if (expIncr[i]) lineAge[i] = lineAge[i] + 2'd1;
        lineAge[t]   = 2'd0;
        lineEmpty[t] = 1'b0;
        lineTag[t]   = addr[ADDR_W-1 -: TAG_SIZE];
        if (we) lineDirty[t] = 1'b1;
        else if (needFill) lineDirty[t] = 1'b0;
    endtask

    // Reset arriving mid-refill must abandon the memory transaction at once,
    // and a late ack must not restart anything.
    task automatic applyResetDuringFill();
        int guard;
        lineEmpty = '1;
        lineHit   = '0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_2040;
        @(negedge clk);
        cpu_req = 1'b0;
        guard   = 0;
        while (mem_rd_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rstfill_reached", mem_rd_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstfill_drop", {cpu_ready, mem_rd_req, mem_wr_req, line_try_read}, 4'b1000);
        checkOutput("rstfill_addr", line_addr, 32'h0);
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rstfill_late_ack", {cpu_ready, mem_rd_req, cpu_done}, 3'b100);
        @(negedge clk);
        checkOutput("rstfill_stays_idle", {cpu_ready, mem_rd_req, line_ready}, 3'b100);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset checks, the directed scenarios, then random traffic.
    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        lineHit   = '0;
        lineEmpty = '1;
        lineDirty = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            lineAge[i]  = 2'd0;
            lineTag[i]  = '0;
            lineData[i] = 8'(8'h10 + i);
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", cpu_ready, 1'b1);
        checkOutput("reset_flags", {cpu_done, multi_hit, line_ready, line_try_read,
                                    line_try_write, mem_rd_req, mem_wr_req}, 7'b0);
        checkOutput("reset_buses", {line_addr, mem_addr}, 64'h0);
        checkOutput("reset_vectors", {line_sel, line_reset_age, line_incr_age, line_wdata, cpu_rdata}, 28'h0);
        rst = 1'b0;
        @(negedge clk);

        // Empty set: refill way 0, then hit on it.
        applyStimulus(1'b0, 32'h0000_1004, 8'h00, 3);
        lineHit = 4'b0001;
        applyStimulus(1'b0, 32'h0000_1004, 8'h00, 0);

        // Fill the remaining ways in order, then re-read way 1.
        for (int w = 1; w < NUM_WAYS; w++) begin
            lineHit = '0;
            applyStimulus(1'b0, 32'h0001_0000 * (w + 1) + 32'h4, 8'h00, 1);
        end
        lineHit = 4'b0010;
        applyStimulus(1'b0, 32'h0002_0004, 8'h00, 0);

        // Oldest way is dirty with a known tag: write-back precedes refill.
        for (int i = 0; i < NUM_WAYS; i++) if (lineAge[i] == 2'd3) begin
            lineDirty[i] = 1'b1;
            lineTag[i]   = 19'h12345;
        end
        lineHit = '0;
        applyStimulus(1'b1, 32'hABCD_E0C8, 8'h5A, 2);

        // Multiple hits resolve to the lowest way.
        lineHit = 4'b0110;
        applyStimulus(1'b0, 32'h0002_0010, 8'h00, 0);

        applyResetDuringFill();

        for (int n = 0; n < 300; n++) begin
            randomizeSet();
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 8'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
